// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the pipeline.
//
// Takes the registered ID/EX fields and computes the ALU result, the signed
// compare / branch decision and the branch target. Every result is registered
// into the stage's own EX/MEM output latch (latency 1 for single-cycle ops).
//
// Build option:
//   MUL_EN  when defined, aluOp 8 runs an iterative shift-add multiplier.
//           It holds stall_req high for DATA_BIT_WIDTH+1 cycles and then
//           registers the low word of the unsigned product. When undefined,
//           aluOp 8 is an undefined code (result 0) and stall_req is tied 0.
//
// Ports:
//   clk, reset (synchronous, active-high), flush (clear outputs, abort multiply)
//   pcIncrementedIn, regData1In, regData2In, immvalIn  datapath operands
//   regWriteNoIn, opcodeIn, wrMemIn, wrRegIn, dstRegMuxSelIn  pass-through control
//   allowBrIn, brBaseMuxSelIn, alu2MuxSelIn, aluOpIn, cmpOpIn  EX control
//   aluResultOut, brTakenOut, brTargetOut  registered results
//   regData2Out, pcIncrementedOut, regWriteNoOut, opcodeOut, wrMemOut,
//   wrRegOut, dstRegMuxSelOut               registered pass-through
//   stall_req  combinational: upstream latches hold while high
module ex_stage #(
    parameter int                        DATA_BIT_WIDTH = 32,
    parameter logic [DATA_BIT_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                        Mux4bit        = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [DATA_BIT_WIDTH-1:0] pcIncrementedIn,
    input  logic [DATA_BIT_WIDTH-1:0] regData1In,
    input  logic [DATA_BIT_WIDTH-1:0] regData2In,
    input  logic [DATA_BIT_WIDTH-1:0] immvalIn,
    input  logic [3:0]                regWriteNoIn,
    input  logic [3:0]                opcodeIn,
    input  logic                      allowBrIn,
    input  logic                      brBaseMuxSelIn,
    input  logic [Mux4bit-1:0]        alu2MuxSelIn,
    input  logic [3:0]                aluOpIn,
    input  logic [3:0]                cmpOpIn,
    input  logic                      wrMemIn,
    input  logic                      wrRegIn,
    input  logic [1:0]                dstRegMuxSelIn,
    output logic [DATA_BIT_WIDTH-1:0] aluResultOut,
    output logic                      brTakenOut,
    output logic [DATA_BIT_WIDTH-1:0] brTargetOut,
    output logic [DATA_BIT_WIDTH-1:0] regData2Out,
    output logic [DATA_BIT_WIDTH-1:0] pcIncrementedOut,
    output logic [3:0]                regWriteNoOut,
    output logic [3:0]                opcodeOut,
    output logic                      wrMemOut,
    output logic                      wrRegOut,
    output logic [1:0]                dstRegMuxSelOut,
    output logic                      stall_req
);
    localparam int W = DATA_BIT_WIDTH;

    typedef struct packed {
        logic [W-1:0] alu_result;
        logic         br_taken;
        logic [W-1:0] br_target;
        logic [W-1:0] reg_data2;
        logic [W-1:0] pc_incremented;
        logic [3:0]   reg_write_no;
        logic [3:0]   opcode;
        logic         wr_mem;
        logic         wr_reg;
        logic [1:0]   dst_reg_mux_sel;
    } ex_out_t;

    function automatic logic [W-1:0] alu_fn(input logic [3:0] op,
                                            input logic signed [W-1:0] a,
                                            input logic signed [W-1:0] b);
        case (op)
            4'h0:    alu_fn = a + b;
            4'h1:    alu_fn = a - b;
            4'h4:    alu_fn = a & b;
            4'h5:    alu_fn = a | b;
            4'h6:    alu_fn = a ^ b;
            4'hC:    alu_fn = ~(a & b);
            4'hD:    alu_fn = ~(a | b);
            4'hE:    alu_fn = ~(a ^ b);
            default: alu_fn = '0;
        endcase
    endfunction

    function automatic logic cmp_fn(input logic [3:0] op,
                                    input logic signed [W-1:0] a,
                                    input logic signed [W-1:0] b);
        case (op)
            4'h1:    cmp_fn = (a == b);
            4'h2:    cmp_fn = (a < b);
            4'h3:    cmp_fn = (a <= b);
            4'h8:    cmp_fn = 1'b1;
            4'h9:    cmp_fn = (a != b);
            4'hA:    cmp_fn = (a >= b);
            4'hB:    cmp_fn = (a > b);
            default: cmp_fn = 1'b0;
        endcase
    endfunction

    // bubble=1 forces the enables low; otherwise every field takes RESET_VALUE
    function automatic ex_out_t reset_fields(input logic bubble);
        reset_fields.alu_result      = RESET_VALUE;
        reset_fields.br_taken        = bubble ? 1'b0 : RESET_VALUE[0];
        reset_fields.br_target       = RESET_VALUE;
        reset_fields.reg_data2       = RESET_VALUE;
        reset_fields.pc_incremented  = RESET_VALUE;
        reset_fields.reg_write_no    = RESET_VALUE[3:0];
        reset_fields.opcode          = RESET_VALUE[3:0];
        reset_fields.wr_mem          = bubble ? 1'b0 : RESET_VALUE[0];
        reset_fields.wr_reg          = bubble ? 1'b0 : RESET_VALUE[0];
        reset_fields.dst_reg_mux_sel = RESET_VALUE[1:0];
    endfunction

    logic signed [W-1:0] op_a_p0;
    logic signed [W-1:0] op_b_p0;
    logic                cmp_p0;
    logic                cmp_mode_p0;
    ex_out_t             calc_p0;
    ex_out_t             nxt_p0;
    ex_out_t             out_p1;

    // ---- stage p0: single-cycle execute ----
    always_comb begin
        op_a_p0 = regData1In;
        case (alu2MuxSelIn)
            Mux4bit'(0): op_b_p0 = regData2In;
            Mux4bit'(1): op_b_p0 = immvalIn;
            Mux4bit'(2): op_b_p0 = immvalIn << 16;
            default:     op_b_p0 = '0;
        endcase
        cmp_p0      = cmp_fn(cmpOpIn, signed'(regData1In), signed'(regData2In));
        // a non-branch compare writes its boolean into the ALU result
        cmp_mode_p0 = (cmpOpIn != 4'h0) && !allowBrIn;

        calc_p0.alu_result      = cmp_mode_p0 ? W'(cmp_p0) : alu_fn(aluOpIn, op_a_p0, op_b_p0);
        calc_p0.br_taken        = allowBrIn & cmp_p0;
        calc_p0.br_target       = (brBaseMuxSelIn ? regData1In : pcIncrementedIn) + (immvalIn << 2);
        calc_p0.reg_data2       = regData2In;
        calc_p0.pc_incremented  = pcIncrementedIn;
        calc_p0.reg_write_no    = regWriteNoIn;
        calc_p0.opcode          = opcodeIn;
        calc_p0.wr_mem          = wrMemIn;
        calc_p0.wr_reg          = wrRegIn;
        calc_p0.dst_reg_mux_sel = dstRegMuxSelIn;
    end

`ifdef MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    mul_state_t    state;
    mul_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  acc;
    ex_out_t       held;
    logic          held_cmp_mode;
    logic          mul_start;
    logic          bubble;

    assign mul_start = (state == IDLE) && (aluOpIn == 4'h8);

    always_ff @(posedge clk) begin
        if (reset || flush) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aluOpIn == 4'h8) state_nxt = BUSY;
            BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bubble    = mul_start || (state == BUSY);
        stall_req = bubble && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset || flush)     cnt <= '0;
        else if (mul_start)     cnt <= '0;
        else if (state == BUSY) cnt <= cnt + CW'(1);
    end

    // operands and control are latched once at entry; nothing is re-sampled mid-op
    always_ff @(posedge clk) begin
        if (mul_start) begin
            mul_a         <= regData1In;
            mul_b         <= op_b_p0;
            acc           <= '0;
            held          <= calc_p0;
            held_cmp_mode <= cmp_mode_p0;
        end else if (state == BUSY) begin
            if (mul_b[0]) acc <= acc + mul_a;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
        end
    end

    always_comb begin
        nxt_p0 = calc_p0;
        if (bubble) begin
            nxt_p0 = reset_fields(1'b1);
        end else if (state == DONE) begin
            nxt_p0 = held;
            if (!held_cmp_mode) nxt_p0.alu_result = acc;
        end
    end
`else
    always_comb begin
        nxt_p0    = calc_p0;
        stall_req = 1'b0;
    end
`endif

    // ---- stage p1: EX/MEM output latch ----
    always_ff @(posedge clk) begin
        if (reset || flush) out_p1 <= reset_fields(1'b0);
        else                out_p1 <= nxt_p0;
    end

    assign aluResultOut     = out_p1.alu_result;
    assign brTakenOut       = out_p1.br_taken;
    assign brTargetOut      = out_p1.br_target;
    assign regData2Out      = out_p1.reg_data2;
    assign pcIncrementedOut = out_p1.pc_incremented;
    assign regWriteNoOut    = out_p1.reg_write_no;
    assign opcodeOut        = out_p1.opcode;
    assign wrMemOut         = out_p1.wr_mem;
    assign wrRegOut         = out_p1.wr_reg;
    assign dstRegMuxSelOut  = out_p1.dst_reg_mux_sel;
endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: scoreboard of expected EX/MEM latch contents,
// one entry pushed per driven cycle and popped after the following edge.
`timescale 1ns/1ps
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        reset, flush;
    logic [31:0] pcIncrementedIn, regData1In, regData2In, immvalIn;
    logic [3:0]  regWriteNoIn, opcodeIn, aluOpIn, cmpOpIn;
    logic        allowBrIn, brBaseMuxSelIn, wrMemIn, wrRegIn;
    logic [1:0]  alu2MuxSelIn, dstRegMuxSelIn;
    logic [31:0] aluResultOut, brTargetOut, regData2Out, pcIncrementedOut;
    logic        brTakenOut, wrMemOut, wrRegOut, stall_req;
    logic [3:0]  regWriteNoOut, opcodeOut;
    logic [1:0]  dstRegMuxSelOut;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .pcIncrementedIn(pcIncrementedIn), .regData1In(regData1In),
        .regData2In(regData2In), .immvalIn(immvalIn),
        .regWriteNoIn(regWriteNoIn), .opcodeIn(opcodeIn),
        .allowBrIn(allowBrIn), .brBaseMuxSelIn(brBaseMuxSelIn),
        .alu2MuxSelIn(alu2MuxSelIn), .aluOpIn(aluOpIn), .cmpOpIn(cmpOpIn),
        .wrMemIn(wrMemIn), .wrRegIn(wrRegIn), .dstRegMuxSelIn(dstRegMuxSelIn),
        .aluResultOut(aluResultOut), .brTakenOut(brTakenOut),
        .brTargetOut(brTargetOut), .regData2Out(regData2Out),
        .pcIncrementedOut(pcIncrementedOut), .regWriteNoOut(regWriteNoOut),
        .opcodeOut(opcodeOut), .wrMemOut(wrMemOut), .wrRegOut(wrRegOut),
        .dstRegMuxSelOut(dstRegMuxSelOut), .stall_req(stall_req)
    );

    typedef struct packed {
        logic [31:0] pc, rd1, rd2, imm;
        logic [3:0]  rwn, opc;
        logic        abr, bsel;
        logic [1:0]  asel;
        logic [3:0]  aop, cop;
        logic        wm, wr;
        logic [1:0]  dsel;
    } in_t;

    typedef struct packed {
        logic [31:0] alu;
        logic        tk;
        logic [31:0] tgt, rd2, pc;
        logic [3:0]  rwn, opc;
        logic        wm, wr;
        logic [1:0]  dsel;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic in_t base_in();
        in_t x;
        x = '0;
        return x;
    endfunction

    function automatic in_t rnd_in();
        in_t x;
        x.pc = $urandom; x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
        x.rwn = 4'($urandom); x.opc = 4'($urandom);
        x.abr = 1'($urandom); x.bsel = 1'($urandom);
        x.asel = 2'($urandom); x.aop = 4'($urandom); x.cop = 4'($urandom);
        x.wm = 1'($urandom); x.wr = 1'($urandom); x.dsel = 2'($urandom);
        return x;
    endfunction

    // Reference behaviour of one instruction, written from the ISA table
    function automatic exp_t model(input in_t x);
        exp_t        e;
        logic [31:0] a, b, alu;
        logic        c;
        a = x.rd1;
        case (x.asel)
            2'd0:    b = x.rd2;
            2'd1:    b = x.imm;
            2'd2:    b = {x.imm[15:0], 16'h0000};
            default: b = 32'h0;
        endcase
        case (x.cop)
            4'h1:    c = (x.rd1 == x.rd2);
            4'h2:    c = ($signed(x.rd1) <  $signed(x.rd2));
            4'h3:    c = ($signed(x.rd1) <= $signed(x.rd2));
            4'h8:    c = 1'b1;
            4'h9:    c = (x.rd1 != x.rd2);
            4'hA:    c = ($signed(x.rd1) >= $signed(x.rd2));
            4'hB:    c = ($signed(x.rd1) >  $signed(x.rd2));
            default: c = 1'b0;
        endcase
        case (x.aop)
            4'h0:    alu = a + b;
            4'h1:    alu = a - b;
            4'h4:    alu = a & b;
            4'h5:    alu = a | b;
            4'h6:    alu = a ^ b;
            4'hC:    alu = ~(a & b);
            4'hD:    alu = ~(a | b);
            4'hE:    alu = ~(a ^ b);
            4'h8: begin
`ifdef MUL_EN
                alu = a * b;
`else
                alu = 32'h0;
`endif
            end
            default: alu = 32'h0;
        endcase
        e.alu  = (x.cop != 4'h0 && !x.abr) ? {31'b0, c} : alu;
        e.tk   = x.abr & c;
        e.tgt  = (x.bsel ? x.rd1 : x.pc) + {x.imm[29:0], 2'b00};
        e.rd2  = x.rd2;
        e.pc   = x.pc;
        e.rwn  = x.rwn;
        e.opc  = x.opc;
        e.wm   = x.wm;
        e.wr   = x.wr;
        e.dsel = x.dsel;
        return e;
    endfunction

    task automatic drive(input in_t x);
        pcIncrementedIn = x.pc;  regData1In = x.rd1; regData2In = x.rd2;
        immvalIn = x.imm;        regWriteNoIn = x.rwn; opcodeIn = x.opc;
        allowBrIn = x.abr;       brBaseMuxSelIn = x.bsel; alu2MuxSelIn = x.asel;
        aluOpIn = x.aop;         cmpOpIn = x.cop; wrMemIn = x.wm; wrRegIn = x.wr;
        dstRegMuxSelIn = x.dsel;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        check_val({tag, ".alu"},  aluResultOut,          e.alu);
        check_val({tag, ".tk"},   32'(brTakenOut),       32'(e.tk));
        check_val({tag, ".tgt"},  brTargetOut,           e.tgt);
        check_val({tag, ".rd2"},  regData2Out,           e.rd2);
        check_val({tag, ".pc"},   pcIncrementedOut,      e.pc);
        check_val({tag, ".rwn"},  32'(regWriteNoOut),    32'(e.rwn));
        check_val({tag, ".opc"},  32'(opcodeOut),        32'(e.opc));
        check_val({tag, ".wm"},   32'(wrMemOut),         32'(e.wm));
        check_val({tag, ".wr"},   32'(wrRegOut),         32'(e.wr));
        check_val({tag, ".dsel"}, 32'(dstRegMuxSelOut),  32'(e.dsel));
    endtask

    // One clock: drive, check the combinational stall, push the expected
    // latch contents, then pop and compare just after the edge.
    task automatic step(input string tag, input in_t x, input logic fl,
                        input logic exp_stall, input exp_t e);
        drive(x);
        flush = fl;
        exp_q.push_back(e);
        #1;
        check_val({tag, ".stall"}, 32'(stall_req), 32'(exp_stall));
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic run(input string tag, input in_t x);
        step(tag, x, 1'b0, 1'b0, model(x));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        in_t x;
        logic [3:0] logic_ops [7];
        logic_ops = '{4'h4, 4'h5, 4'h6, 4'hC, 4'hD, 4'hE, 4'h7};
        flush = 1'b0;
        reset = 1'b1;
        x = rnd_in(); x.aop = 4'h8;
        step("reset0", x, 1'b0, 1'b0, zero_exp());
        x = rnd_in();
        step("reset1", x, 1'b0, 1'b0, zero_exp());
        reset = 1'b0;

        x = base_in(); x.rd1 = 32'hFFFF_FFFF; x.imm = 32'h1; x.asel = 2'd1;
        x.aop = 4'h0; x.wr = 1'b1; x.rwn = 4'd5; x.opc = 4'h3; x.dsel = 2'd2;
        run("add_wrap", x);

        x = base_in(); x.rd1 = 32'd3; x.rd2 = 32'd5; x.aop = 4'h1; x.wm = 1'b1;
        run("sub", x);

        foreach (logic_ops[i]) begin
            x = rnd_in(); x.aop = logic_ops[i]; x.cop = 4'h0;
            run("logic", x);
        end

        x = base_in(); x.rd1 = 32'h0000_00F0; x.imm = 32'h0000_1234; x.asel = 2'd2; x.aop = 4'h5;
        run("or_lui", x);

        x = base_in(); x.rd1 = 32'd5; x.rd2 = 32'd5; x.cop = 4'h1; x.abr = 1'b1;
        x.bsel = 1'b0; x.pc = 32'h100; x.imm = 32'd3;
        run("beq", x);

        x = base_in(); x.rd1 = 32'h8000_0000; x.rd2 = 32'd1; x.cop = 4'h2; x.abr = 1'b1;
        run("blt_signed", x);
        x.cop = 4'hB;
        run("bgt_signed", x);

        x = base_in(); x.cop = 4'h0; x.abr = 1'b1; x.rd1 = 32'd9; x.rd2 = 32'd9;
        run("br_false", x);
        x = base_in(); x.cop = 4'h8; x.abr = 1'b1; x.bsel = 1'b1;
        x.rd1 = 32'h0000_0010; x.imm = 32'hFFFF_FFFE; x.wr = 1'b1;
        run("jal_reg", x);
        x = base_in(); x.cop = 4'h3; x.abr = 1'b0; x.rd1 = 32'hFFFF_FFFF; x.rd2 = 32'd0;
        run("slt_mode", x);

        x = base_in(); x.rd1 = 32'd1; x.rd2 = 32'd2; x.aop = 4'h0; x.wr = 1'b1;
        step("flush", x, 1'b1, 1'b0, zero_exp());

        for (int i = 0; i < 20; i++) begin
            x = rnd_in();
`ifdef MUL_EN
            if (x.aop == 4'h8) x.aop = 4'h0;
`endif
            run("random", x);
        end

`ifndef MUL_EN
        x = base_in(); x.rd1 = 32'd7; x.rd2 = 32'd6; x.aop = 4'h8; x.wr = 1'b1;
        run("mul_off", x);
`else
        x = base_in(); x.rd1 = 32'd7; x.rd2 = 32'd6; x.aop = 4'h8;
        x.wr = 1'b1; x.rwn = 4'd3; x.pc = 32'h40; x.imm = 32'd2;
        for (int k = 0; k < 33; k++) step("mul_busy", x, 1'b0, 1'b1, zero_exp());
        run("mul_done", x);

        x = base_in(); x.rd1 = 32'hFFFF_FFFF; x.imm = 32'd3; x.asel = 2'd1;
        x.aop = 4'h8; x.wr = 1'b1;
        for (int k = 0; k < 33; k++) step("mul2_busy", x, 1'b0, 1'b1, zero_exp());
        run("mul2_done", x);

        x = base_in(); x.rd1 = 32'd11; x.rd2 = 32'd13; x.aop = 4'h8; x.wr = 1'b1;
        for (int k = 0; k < 10; k++) step("mulf_busy", x, 1'b0, 1'b1, zero_exp());
        step("mulf_flush", x, 1'b1, 1'b1, zero_exp());
        x = base_in(); x.rd1 = 32'd20; x.rd2 = 32'd22; x.aop = 4'h0; x.wr = 1'b1;
        run("add_after_flush", x);

        x = base_in(); x.rd1 = 32'd2; x.rd2 = 32'd3; x.aop = 4'h8; x.wr = 1'b1;
        step("mul_entry_flush", x, 1'b1, 1'b1, zero_exp());
        x = base_in(); x.rd1 = 32'd4; x.imm = 32'd5; x.asel = 2'd1; x.aop = 4'h0; x.wr = 1'b1;
        run("add_after_entry_flush", x);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
